// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: ALU opcodes, forward-select codes and bubble value shared by the ID/EX stage.
package id_ex_stage_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [1:0] FWD_ID  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam logic [31:0] BUBBLE_DATA = 32'h0;
endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// hazard_unit: combinational forward selects and stall for the ID/EX stage.
// ID_EX_FWD_EN enables forwarding; without it every RAW match against EX or MEM stalls.
module hazard_unit
    import id_ex_stage_pkg::*;
(
    input  logic       id_valid,
    input  logic       flush,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       ex_valid,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_rd,
    input  logic       mem_wreg,
    input  logic [4:0] mem_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       stall
);
    logic rs_ex, rt_ex, rs_mem, rt_mem, load_use;

    // register 0 never matches, so it is neither forwarded nor a hazard
    assign rs_ex    = ex_valid & (id_rs != 5'd0) & (ex_rd == id_rs);
    assign rt_ex    = ex_valid & (id_rt != 5'd0) & (ex_rd == id_rt);
    assign rs_mem   = mem_wreg & (id_rs != 5'd0) & (mem_rd == id_rs);
    assign rt_mem   = mem_wreg & (id_rt != 5'd0) & (mem_rd == id_rt);
    assign load_use = ex_m2reg & ((id_rs_used & rs_ex) | (id_rt_used & rt_ex));

`ifdef ID_EX_FWD_EN
    assign fwd_a = (rs_ex & ex_wreg & !ex_m2reg) ? FWD_EX : rs_mem ? FWD_MEM : FWD_ID;
    assign fwd_b = (rt_ex & ex_wreg & !ex_m2reg) ? FWD_EX : rt_mem ? FWD_MEM : FWD_ID;
    assign stall = id_valid & !flush & load_use;
`else
    assign fwd_a = FWD_ID;
    assign fwd_b = FWD_ID;
    assign stall = id_valid & !flush & (load_use
                 | (id_rs_used & ((rs_ex & ex_wreg) | rs_mem))
                 | (id_rt_used & ((rt_ex & ex_wreg) | rt_mem)));
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU, with operand forwarding and hazard stall.
// Optional forwarding is enabled by defining ID_EX_FWD_EN.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [31:0]            id_ra,
    input  logic [31:0]            id_rb,
    input  logic [31:0]            id_imm,
    input  logic [4:0]             id_shamt,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             id_rd,
    input  logic                   id_rs_used,
    input  logic                   id_rt_used,
    input  logic [3:0]             id_aluc,
    input  logic                   id_aluimm,
    input  logic                   id_shift,
    input  logic                   id_wreg,
    input  logic                   id_m2reg,
    input  logic                   id_wmem,
    input  logic                   flush,
    input  logic [31:0]            ex_result,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_wreg,
    input  logic [31:0]            mem_data,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [3:0]             alu_aluc,
    output logic [31:0]            ex_store_data,
    output logic [4:0]             ex_rd,
    output logic                   ex_valid,
    output logic                   ex_wreg,
    output logic                   ex_m2reg,
    output logic                   ex_wmem,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] fwd_rs, fwd_rt, sel_a, sel_b;
    logic        bubble;

    hazard_unit u_hazard (
        .id_valid   (id_valid),
        .flush      (flush),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .ex_valid   (ex_valid),
        .ex_wreg    (ex_wreg),
        .ex_m2reg   (ex_m2reg),
        .ex_rd      (ex_rd),
        .mem_wreg   (mem_wreg),
        .mem_rd     (mem_rd),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall      (stall)
    );

    assign fwd_rs = (fwd_a == FWD_EX) ? ex_result : (fwd_a == FWD_MEM) ? mem_data : id_ra;
    assign fwd_rt = (fwd_b == FWD_EX) ? ex_result : (fwd_b == FWD_MEM) ? mem_data : id_rb;
    assign sel_a  = id_shift ? fwd_rt : fwd_rs;
    assign sel_b  = id_shift ? {27'b0, id_shamt} : id_aluimm ? id_imm : fwd_rt;
    assign bubble = flush | stall | !id_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset || bubble) begin
            alu_a         <= BUBBLE_DATA;
            alu_b         <= BUBBLE_DATA;
            alu_aluc      <= ALU_ADD;
            ex_store_data <= BUBBLE_DATA;
            ex_rd         <= 5'd0;
            ex_valid      <= 1'b0;
            ex_wreg       <= 1'b0;
            ex_m2reg      <= 1'b0;
            ex_wmem       <= 1'b0;
        end else begin
            alu_a         <= sel_a;
            alu_b         <= sel_b;
            alu_aluc      <= id_aluc;
            ex_store_data <= fwd_rt;
            ex_rd         <= id_rd;
            ex_valid      <= 1'b1;
            ex_wreg       <= id_wreg;
            ex_m2reg      <= id_m2reg;
            ex_wmem       <= id_wmem;
        end
    end

    // saturates at all-ones rather than wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
